pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_ras.sv | 59 +++++
 rtl/pc_unit.sv | 110 +++++++++++
 tb/tb_pc_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC source encoding for the program-counter unit.
package pc_pkg;

  localparam int          PC_W_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;
  localparam int          INC_DEF       = 4;
  localparam int          RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_JMP,
    SRC_RET,
    SRC_BR,
    SRC_EXC
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry and keeps the count saturated.
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_replace,
  input  logic                           i_clear,
  input  logic [PC_W-1:0]                i_data,
  output logic [PC_W-1:0]                o_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_sp;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_sp_inc;
  logic [PTR_W-1:0] w_sp_dec;
  logic             w_full;

  // r_sp always points at the next free slot, so the top lives one slot below it
  assign w_sp_inc = (r_sp == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_sp + PTR_W'(1);
  assign w_sp_dec = (r_sp == '0) ? PTR_W'(RAS_DEPTH - 1) : r_sp - PTR_W'(1);
  assign w_full   = (r_count == CNT_W'(RAS_DEPTH));
  assign o_top    = r_mem[w_sp_dec];
  assign o_count  = r_count;

  always_ff @(posedge clk_i) begin
    if (i_push)
      r_mem[r_sp] <= i_data;
    else if (i_replace)
      r_mem[w_sp_dec] <= i_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_sp    <= w_sp_inc;
      r_count <= w_full ? r_count : r_count + CNT_W'(1);
    end else if (i_pop) begin
      r_sp    <= w_sp_dec;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC selection, stall handling, RAS push/pop and flush flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF),
  parameter int              INC       = INC_DEF,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            exc_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus_o,
  output logic            redirect_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  r_pc;
  logic             r_redirect;
  logic [PC_W-1:0]  w_next_pc;
  logic [PC_W-1:0]  w_ras_top;
  logic [CNT_W-1:0] w_ras_count;
  pc_src_e          w_src;
  logic             w_hold;
  logic             w_push;
  logic             w_pop;
  logic             w_replace;
  logic             w_clear;

  assign pc_o        = r_pc;
  assign pc_plus_o   = r_pc + PC_W'(INC);
  assign redirect_o  = r_redirect;
  assign ras_empty_o = (w_ras_count == '0);
  assign ras_full_o  = (w_ras_count == CNT_W'(RAS_DEPTH));

  always_comb begin
    w_src     = SRC_SEQ;
    w_hold    = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_replace = 1'b0;
    w_clear   = 1'b0;
    if (exc_i) begin
      w_src   = SRC_EXC;
      w_clear = 1'b1;
    end else if (br_taken_i) begin
      w_src = SRC_BR;
    end else if (stall_i) begin
      w_hold = 1'b1;
    end else if (ret_i && !ras_empty_o) begin
      // a simultaneous call swaps the top in place instead of popping then pushing
      w_src     = SRC_RET;
      w_replace = call_i;
      w_pop     = !call_i;
    end else if (jmp_i) begin
      w_src  = SRC_JMP;
      w_push = call_i;
    end
  end

  always_comb begin
    unique case (w_src)
      SRC_EXC: w_next_pc = EXC_VEC;
      SRC_BR:  w_next_pc = br_target_i;
      SRC_RET: w_next_pc = w_ras_top;
      SRC_JMP: w_next_pc = jmp_target_i;
      default: w_next_pc = pc_plus_o;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= RESET_VEC;
      r_redirect <= 1'b0;
    end else if (w_hold) begin
      r_redirect <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_redirect <= (w_src != SRC_SEQ);
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_replace (w_replace),
    .i_clear   (w_clear),
    .i_data    (pc_plus_o),
    .o_top     (w_ras_top),
    .o_count   (w_ras_count)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expectations are queued as each step is driven and popped when checked.
module tb_pc_unit;
  import pc_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, exc, br, jmp, call, ret;
  logic [31:0] br_tgt, jmp_tgt;
  logic [31:0] pc, pc_plus;
  logic        redirect, empty, full;

  logic        rst8, stall8;
  logic [7:0]  pc8, plus8;
  logic        redir8, empty8, full8;

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc;
  logic [31:0] tgt;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .exc_i(exc),
    .br_taken_i(br), .br_target_i(br_tgt), .jmp_i(jmp), .jmp_target_i(jmp_tgt),
    .call_i(call), .ret_i(ret), .pc_o(pc), .pc_plus_o(pc_plus),
    .redirect_o(redirect), .ras_empty_o(empty), .ras_full_o(full)
  );

  pc_unit #(.PC_W(8), .RESET_VEC(8'hF8), .INC(4)) dut8 (
    .clk_i(clk), .rst_i(rst8), .stall_i(stall8), .exc_i(1'b0),
    .br_taken_i(1'b0), .br_target_i(8'h00), .jmp_i(1'b0), .jmp_target_i(8'h00),
    .call_i(1'b0), .ret_i(1'b0), .pc_o(pc8), .pc_plus_o(plus8),
    .redirect_o(redir8), .ras_empty_o(empty8), .ras_full_o(full8)
  );

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
      $display("check %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    stall = 0; exc = 0; br = 0; jmp = 0; call = 0; ret = 0;
    br_tgt = '0; jmp_tgt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    stall8 = 0;
    rst = 1; rst8 = 1;
    #1;
    expect_v("rst_pc", 32'h0);    chk(pc);
    expect_v("rst_redir", 32'h0); chk({31'b0, redirect});
    expect_v("rst_empty", 32'h1); chk({31'b0, empty});
    expect_v("rst_full", 32'h0);  chk({31'b0, full});
    tick();
    expect_v("held_rst_pc", 32'h0); chk(pc);
    rst = 0; rst8 = 0;

    for (int i = 1; i <= 3; i++) begin
      expect_v("seq_pc", 32'(i * 4));
      expect_v("seq_redir", 32'h0);
      tick();
      chk(pc);
      chk({31'b0, redirect});
    end
    expect_v("pc_plus", 32'h10); chk(pc_plus);

    rst = 1; #1;
    expect_v("async_rst_pc", 32'h0); chk(pc);
    rst = 0;
    tick(); tick();
    expect_v("pre_br_pc", 32'h8); chk(pc);

    stall = 1; br = 1; br_tgt = 32'h40;
    expect_v("br_stall_pc", 32'h40); expect_v("br_redir", 32'h1);
    tick(); chk(pc); chk({31'b0, redirect});
    idle();
    expect_v("after_br_pc", 32'h44); expect_v("after_br_redir", 32'h0);
    tick(); chk(pc); chk({31'b0, redirect});

    jmp = 1; jmp_tgt = 32'h10;
    expect_v("jmp_pc", 32'h10); expect_v("jmp_redir", 32'h1);
    tick(); chk(pc); chk({31'b0, redirect});
    call = 1; jmp_tgt = 32'h100;
    expect_v("call_pc", 32'h100); expect_v("call_nonempty", 32'h0);
    tick(); chk(pc); chk({31'b0, empty});
    idle();
    expect_v("callee_seq", 32'h104);
    tick(); chk(pc);
    ret = 1;
    expect_v("ret_pc", 32'h14); expect_v("ret_empty", 32'h1); expect_v("ret_redir", 32'h1);
    tick(); chk(pc); chk({31'b0, empty}); chk({31'b0, redirect});
    idle();

    m_pc = 32'h14;
    for (int k = 0; k < 5; k++) begin
      tgt = 32'h200 + 32'(k) * 32'h100;
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
      jmp = 1; call = 1; jmp_tgt = tgt;
      expect_v("nest_call_pc", tgt);
      expect_v("nest_full", (k >= 3) ? 32'h1 : 32'h0);
      tick(); chk(pc); chk({31'b0, full});
      m_pc = tgt;
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      ret = 1;
      m_pc = m_ras.pop_back();
      expect_v("lifo_ret_pc", m_pc);
      tick(); chk(pc);
    end
    expect_v("drained_empty", 32'h1); chk({31'b0, empty});
    expect_v("ret_empty_seq", m_pc + 32'd4); expect_v("ret_empty_redir", 32'h0);
    tick(); chk(pc); chk({31'b0, redirect});
    m_pc = m_pc + 32'd4;

    ret = 0; stall = 1; jmp = 1; call = 1; jmp_tgt = 32'h900;
    expect_v("stall_hold_pc", m_pc); expect_v("stall_hold_empty", 32'h1);
    expect_v("stall_hold_redir", 32'h0);
    tick(); chk(pc); chk({31'b0, empty}); chk({31'b0, redirect});

    stall = 0; jmp_tgt = 32'h700;
    tick();
    jmp_tgt = 32'h800;
    tick();
    expect_v("two_calls_pc", 32'h800); chk(pc);
    expect_v("two_calls_empty", 32'h0); chk({31'b0, empty});
    jmp = 0; call = 0; stall = 1; exc = 1;
    expect_v("exc_pc", 32'h80); expect_v("exc_empty", 32'h1); expect_v("exc_redir", 32'h1);
    tick(); chk(pc); chk({31'b0, empty}); chk({31'b0, redirect});
    exc = 0;
    expect_v("post_exc_hold", 32'h80); expect_v("post_exc_redir", 32'h0);
    tick(); chk(pc); chk({31'b0, redirect});

    stall = 0; jmp = 1; call = 1; jmp_tgt = 32'hA00;
    rst = 1; #1;
    expect_v("rst_midcall_pc", 32'h0); expect_v("rst_midcall_empty", 32'h1);
    chk(pc); chk({31'b0, empty});
    tick();
    expect_v("rst_held_pc", 32'h0); chk(pc);
    rst = 0; idle();
    expect_v("rst_release_pc", 32'h4); expect_v("rst_release_empty", 32'h1);
    tick(); chk(pc); chk({31'b0, empty});

    rst8 = 1; #1;
    expect_v("w8_rst_pc", 32'hF8); chk({24'b0, pc8});
    rst8 = 0;
    expect_v("w8_pc_fc", 32'hFC); expect_v("w8_plus_wrap", 32'h00);
    tick(); chk({24'b0, pc8}); chk({24'b0, plus8});
    expect_v("w8_wrap_pc", 32'h00);
    tick(); chk({24'b0, pc8});
    stall8 = 1;
    expect_v("w8_stall_pc", 32'h00);
    tick(); chk({24'b0, pc8});
    rst8 = 1; #1;
    expect_v("w8_rst_midstall", 32'hF8); chk({24'b0, pc8});
    rst8 = 0; stall8 = 0;

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
